mem_port_arbiter: RTL and testbench

//   Shares the single-ported 256x8 unified memory of CPU_WrapperV3 between the IF-stage fetch port and
//   the MEM-stage data port (LDD/STD/PUSH/POP). Resolves the structural hazard of 2-byte/data instrs.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle for the shared memory port: fetch requester, data requester and the memory side.
// slave = the arbiter, master = the CPU pipeline plus the memory it drives.
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_stall;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          flush;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_stall;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_stall, if_rvalid, if_rdata, d_gnt, d_stall, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_stall, if_rvalid, if_rdata, d_gnt, d_stall, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and the data stage,
// with a starvation guard for fetch, branch flush of wrong-path fetch data and read-data routing.
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  mem_port_arbiter_if.slave    bus
);
  localparam int              CW         = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]   STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  owner_t        owner_r;
  logic [CW-1:0] cnt_r;
  logic          fetch_elig_s;
  logic          data_elig_s;
  logic          if_gnt_s;
  logic          d_gnt_s;
  logic          mem_we_s;
  logic [AW-1:0] mem_addr_s;
  logic [DW-1:0] mem_wdata_s;
  logic          if_rvalid_s;
  logic          d_rvalid_s;

  // Grant decision; rstn gates eligibility so every output reads 0 while reset is held.
  always_comb begin
    fetch_elig_s = rstn & bus.if_req & ~bus.flush;
    data_elig_s  = rstn & bus.d_req;
    if_gnt_s     = 1'b0;
    d_gnt_s      = 1'b0;
    if (fetch_elig_s && data_elig_s) begin
      if (cnt_r == STARVE_LIM) begin
        if_gnt_s = 1'b1;
      end else begin
        d_gnt_s = 1'b1;
      end
    end else if (fetch_elig_s) begin
      if_gnt_s = 1'b1;
    end else if (data_elig_s) begin
      d_gnt_s = 1'b1;
    end else begin
      if_gnt_s = 1'b0;
      d_gnt_s  = 1'b0;
    end
  end

  // Memory port is driven by the winner only; fetch never writes.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = '0;
    mem_wdata_s = '0;
    if (d_gnt_s) begin
      mem_we_s    = bus.d_we;
      mem_addr_s  = bus.d_addr;
      mem_wdata_s = bus.d_wdata;
    end else if (if_gnt_s) begin
      mem_addr_s  = bus.if_addr;
    end else begin
      mem_we_s    = 1'b0;
      mem_addr_s  = '0;
      mem_wdata_s = '0;
    end
  end

  // Read-response owner and count of consecutive contended cycles fetch has lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner_r <= OWN_NONE;
      cnt_r   <= '0;
    end else begin
      if (if_gnt_s) begin
        owner_r <= OWN_IF;
      end else if (d_gnt_s && !bus.d_we) begin
        owner_r <= OWN_D;
      end else begin
        owner_r <= OWN_NONE;
      end
      if (fetch_elig_s && d_gnt_s && (cnt_r != STARVE_LIM)) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= '0;
      end
    end
  end

  // Route last cycle's read data to its owner; a flush kills the wrong-path fetch word.
  always_comb begin
    if_rvalid_s = 1'b0;
    d_rvalid_s  = 1'b0;
    case (owner_r)
      OWN_IF:  if_rvalid_s = ~bus.flush;
      OWN_D:   d_rvalid_s  = 1'b1;
      default: begin
        if_rvalid_s = 1'b0;
        d_rvalid_s  = 1'b0;
      end
    endcase
  end

  assign bus.if_gnt    = if_gnt_s;
  assign bus.if_stall  = fetch_elig_s & ~if_gnt_s;
  assign bus.if_rvalid = if_rvalid_s;
  assign bus.if_rdata  = if_rvalid_s ? bus.mem_rdata : '0;
  assign bus.d_gnt     = d_gnt_s;
  assign bus.d_stall   = data_elig_s & ~d_gnt_s;
  assign bus.d_rvalid  = d_rvalid_s;
  assign bus.d_rdata   = d_rvalid_s ? bus.mem_rdata : '0;
  assign bus.mem_en    = if_gnt_s | d_gnt_s;
  assign bus.mem_we    = mem_we_s;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_wdata = mem_wdata_s;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: stimulus predicts grants and read data from a shadow memory and the
// arbitration rules; a negedge monitor compares the DUT against the queued expectations.
module tb_mem_port_arbiter;
  localparam int AW         = 8;
  localparam int DW         = 8;
  localparam int STARVE_MAX = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus();

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    int         cyc;
    bit         rst;
    logic [5:0] ctrl;   // {if_gnt, d_gnt, if_stall, d_stall, mem_en, mem_we}
    logic [7:0] addr;
    logic [7:0] wdata;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } rsp_t;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  exp_t       gnt_q [$];
  rsp_t       if_q  [$];
  rsp_t       d_q   [$];
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;
  int         losses = 0;
  exp_t       mon_e;
  rsp_t       mon_r;
  bit         mon_iv;
  bit         mon_dv;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port memory with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus plus the reference prediction for that clock.
  task automatic drive(bit ir, logic [7:0] ia, bit fl, bit dr, bit dw,
                       logic [7:0] da, logic [7:0] dwd, bit rst_low);
    exp_t e;
    bit   fe, fetch_wins, data_wins;
    @(posedge clk);
    #1;
    rstn        = ~rst_low;
    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.flush   = fl;
    bus.d_req   = dr;
    bus.d_we    = dw;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
    e.cyc   = cyc;
    e.rst   = rst_low;
    e.ctrl  = 6'd0;
    e.addr  = 8'd0;
    e.wdata = 8'd0;
    if (rst_low) begin
      losses = 0;
      if_q.delete();
      d_q.delete();
    end else begin
      if (fl && if_q.size() > 0 && if_q[0].cyc == cyc) void'(if_q.pop_front());
      fe         = ir && !fl;
      fetch_wins = 1'b0;
      data_wins  = 1'b0;
      if (fe && dr) begin
        if (losses >= STARVE_MAX) fetch_wins = 1'b1;
        else                      data_wins  = 1'b1;
      end else begin
        fetch_wins = fe;
        data_wins  = dr;
      end
      losses = (fe && data_wins) ? losses + 1 : 0;
      e.ctrl = {fetch_wins, data_wins, fe && !fetch_wins, dr && !data_wins,
                fetch_wins || data_wins, data_wins && dw};
      if (fetch_wins) begin
        e.addr = ia;
        if_q.push_back('{cyc + 1, ref_mem[ia]});
      end else if (data_wins) begin
        e.addr  = da;
        e.wdata = dwd;
        if (dw) ref_mem[da] = dwd;
        else    d_q.push_back('{cyc + 1, ref_mem[da]});
      end
    end
    gnt_q.push_back(e);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  // Monitor: per-cycle grant/memory checks and scoreboard pops on rvalid.
  initial begin
    forever begin
      @(negedge clk);
      if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
        mon_e = gnt_q.pop_front();
        if (mon_e.rst) begin
          chk("reset_outputs",
              {bus.if_gnt, bus.if_stall, bus.if_rvalid, bus.if_rdata,
               bus.d_gnt, bus.d_stall, bus.d_rvalid, bus.d_rdata,
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 64'd0);
        end else begin
          chk("grant_ctrl", {bus.if_gnt, bus.d_gnt, bus.if_stall, bus.d_stall,
                             bus.mem_en, bus.mem_we}, mon_e.ctrl);
          chk("mem_addr", bus.mem_addr, mon_e.addr);
          chk("mem_wdata", bus.mem_wdata, mon_e.wdata);
          mon_iv = if_q.size() > 0 && if_q[0].cyc == cyc;
          mon_dv = d_q.size() > 0 && d_q[0].cyc == cyc;
          chk("if_rvalid", bus.if_rvalid, mon_iv);
          chk("d_rvalid", bus.d_rvalid, mon_dv);
          if (mon_iv) begin
            mon_r = if_q.pop_front();
            chk("if_rdata", bus.if_rdata, mon_r.data);
          end else begin
            chk("if_rdata_zero", bus.if_rdata, 64'd0);
          end
          if (mon_dv) begin
            mon_r = d_q.pop_front();
            chk("d_rdata", bus.d_rdata, mon_r.data);
          end else begin
            chk("d_rdata_zero", bus.d_rdata, 64'd0);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'hC5;
    mem[8'h01] = 8'hF0;
    mem[8'hF0] = 8'hAA;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    bus.mem_rdata = 8'h00;

    for (int i = 0; i < 3; i++) drive(1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 8'h09, 8'h00, 1'b1);
    idle(2);
    // fetch only, consecutive addresses
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    idle(1);
    // data load contends with fetch, fetch retried next cycle
    drive(1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 8'hF0, 8'h00, 1'b0);
    drive(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    idle(1);
    // six contended cycles exercise the starvation guard
    for (int i = 0; i < 6; i++) drive(1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 8'(8'h20 + i), 8'h00, 1'b0);
    idle(1);
    // write then read back, fetch of the same address sees the new value
    drive(1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 8'h10, 8'h55, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    drive(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    idle(1);
    // flush kills the fetch issued the cycle before, data takes the port
    drive(1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0);
    idle(1);
    // reset right after a read grant
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0);
    drive(1'b1, 8'h06, 1'b0, 1'b1, 1'b0, 8'h41, 8'h00, 1'b1);
    drive(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    idle(1);

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 7, 8'($urandom_range(0, 15)), $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, 8'($urandom_range(0, 15)),
            8'($urandom), $urandom_range(0, 99) == 0);
    end
    idle(3);
    @(negedge clk);
    #1;
    chk("queues_drained", 64'(gnt_q.size() + if_q.size() + d_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
